alu_issue_ctrl: RTL

Sequential issue/capture controller that drives the 4-bit combinational `ALU` (opcode `s[4:0]`, carry-in, 5-bit result `c[4:0]`) from the initiator side. It accepts one command per valid/ready handshake and presents operands and opcode to the ALU on registered outputs. After a programmable settle time it captures the ALU result into a result register and a 4-bit accumulator, then returns the result on a valid/ready response channel. It sits between the instruction source and the `ALU` instance.

---
 rtl/alu_issue_ctrl_if.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Command/response bundle between an instruction source and alu_issue_ctrl.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high. The initiator keeps valid and
// its payload stable until that edge. Ready never depends on valid in the
// same cycle.
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_op;
  logic       cmd_cin;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_a_acc;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_data;

  // Instruction source side: issues commands, consumes results.
  modport master (
    output cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, cmd_a_acc, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, cmd_a_acc, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for a 4-bit combinational ALU.
// Accepts one command, holds operands on registered ALU inputs for SETTLE
// cycles, captures the ALU result into res_data and the accumulator, then
// offers it on the response channel. state_dbg mirrors the FSM encoding
// (0 idle, 1 issue, 2 resp) for observation.
module alu_issue_ctrl #(
  parameter int SETTLE  = 1,   // 1..15
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_ctrl_if.slave    bus,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [4:0]         alu_s,
  output logic               alu_cin,
  input  logic [4:0]         alu_c,
  output logic [3:0]         acc,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [4:0] res_data_q;

  // Handshake flags come straight from the state register, so nothing on
  // the input side reaches cmd_ready or res_valid combinationally.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == RESP);
  assign bus.res_data  = res_data_q;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // Controller FSM: accept, hold ALU inputs for the settle time, capture,
  // then wait for the consumer. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      alu_cin    <= 1'b0;
      res_data_q <= '0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_s      <= bus.cmd_op;
            alu_cin    <= bus.cmd_cin;
            alu_b      <= bus.cmd_b;
            // Accumulator value as it stands at the accept edge.
            alu_a      <= bus.cmd_a_acc ? acc : bus.cmd_a;
            settle_cnt <= SETTLE_M1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            res_data_q <= alu_c;
            acc        <= alu_c[3:0];   // carry bit is not accumulated
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            op_count <= op_count + COUNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
